// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file and the datapath that
// uses it: default register width/index width, the sweep FSM state encoding
// and a constant-evaluable ceil(log2) helper.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_e;

    // ceil(log2(value)); returns 0 for value <= 1. Fixed loop bound keeps it
    // usable in constant expressions and synthesis.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus bundle between the datapath (master) and the register file (slave).
//   ReadRegOne/ReadRegTwo   : read indices            (master -> slave)
//   ReadDataOne/ReadDataTwo : combinational read data (slave -> master)
//   WriteRegA/B, WriteDataA/B, RegWriteA/B : two write ports (master -> slave)
//   Ready                   : array valid and accepting writes (slave -> master)
// -----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] ReadRegOne;
    logic [ADDR_WIDTH-1:0] ReadRegTwo;
    logic [DATA_WIDTH-1:0] ReadDataOne;
    logic [DATA_WIDTH-1:0] ReadDataTwo;
    logic [ADDR_WIDTH-1:0] WriteRegA;
    logic [DATA_WIDTH-1:0] WriteDataA;
    logic                  RegWriteA;
    logic [ADDR_WIDTH-1:0] WriteRegB;
    logic [DATA_WIDTH-1:0] WriteDataB;
    logic                  RegWriteB;
    logic                  Ready;

    modport master (
        output ReadRegOne, ReadRegTwo,
        output WriteRegA, WriteDataA, RegWriteA,
        output WriteRegB, WriteDataB, RegWriteB,
        input  ReadDataOne, ReadDataTwo, Ready
    );

    modport slave (
        input  ReadRegOne, ReadRegTwo,
        input  WriteRegA, WriteDataA, RegWriteA,
        input  WriteRegB, WriteDataB, RegWriteB,
        output ReadDataOne, ReadDataTwo, Ready
    );

endinterface

// File: rtl/regfile_read_mux.sv
// -----------------------------------------------------------------------------
// regfile_read_mux
// Output select for one read port: forced zero while the array is not ready,
// hardwired register 0, write-to-read bypass (port B over port A), otherwise
// the stored array word.
//   rd_idx    : read index
//   arr_data  : array word at rd_idx
//   we_a/b, wr_idx_a/b, wr_data_a/b : write ports seen this cycle
//   ready     : array valid
//   rd_data   : selected read data
// -----------------------------------------------------------------------------
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    input  logic [DATA_WIDTH-1:0] arr_data,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] wr_idx_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] wr_idx_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] rd_data
);

    always_comb begin
        rd_data = arr_data;
        // Order of tests is the priority order: not-ready and register 0
        // dominate any bypass.
        if (!ready) begin
            rd_data = '0;
        end else if ((ZERO_REG != 0) && (rd_idx == '0)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && we_b && (wr_idx_b == rd_idx)) begin
            rd_data = wr_data_b;
        end else if ((BYPASS != 0) && we_a && (wr_idx_a == rd_idx)) begin
            rd_data = wr_data_a;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Two-read / two-write register file. Storage has no reset; after Reset a
// sweep clears CLEAR_LANES entries per cycle and Ready rises once the last
// group is cleared. Writes are ignored and reads return 0 until then.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high; restarts the clear sweep
//   bus   : regfile_mp_if slave (read/write ports and Ready)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int CLEAR_LANES = 4,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic         Clock,
    input  logic         Reset,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int LANE_BITS = clog2(CLEAR_LANES);
    localparam int CNT_W_RAW = ADDR_WIDTH - LANE_BITS;
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int GROUPS    = DEPTH / CLEAR_LANES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    regfile_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  clear_en;
    logic [ADDR_WIDTH-1:0] clr_base;
    logic                  wr_a_en;
    logic                  wr_b_en;
    logic [DATA_WIDTH-1:0] rd_one;
    logic [DATA_WIDTH-1:0] rd_two;

    // Sweep FSM: state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Sweep FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Array write controls; Reset suppresses every array write in its cycle.
    always_comb begin
        clear_en = !Reset && (state_q == CLEAR);
        clr_base = ADDR_WIDTH'(cnt_q) << LANE_BITS;
        wr_a_en  = !Reset && (state_q == RUN) && bus.RegWriteA &&
                   !((ZERO_REG != 0) && (bus.WriteRegA == '0));
        wr_b_en  = !Reset && (state_q == RUN) && bus.RegWriteB &&
                   !((ZERO_REG != 0) && (bus.WriteRegB == '0));
    end

    // Storage: no reset, cleared by the sweep. Port B is assigned last so it
    // wins when both ports hit the same index.
    always_ff @(posedge Clock) begin
        if (clear_en) begin
            for (int l = 0; l < CLEAR_LANES; l++) begin
                regs_q[clr_base + ADDR_WIDTH'(l)] <= '0;
            end
        end else begin
            if (wr_a_en) begin
                regs_q[bus.WriteRegA] <= bus.WriteDataA;
            end
            if (wr_b_en) begin
                regs_q[bus.WriteRegB] <= bus.WriteDataB;
            end
        end
    end

    regfile_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_one (
        .rd_idx    (bus.ReadRegOne),
        .arr_data  (regs_q[bus.ReadRegOne]),
        .we_a      (bus.RegWriteA),
        .wr_idx_a  (bus.WriteRegA),
        .wr_data_a (bus.WriteDataA),
        .we_b      (bus.RegWriteB),
        .wr_idx_b  (bus.WriteRegB),
        .wr_data_b (bus.WriteDataB),
        .ready     (ready_q),
        .rd_data   (rd_one)
    );

    regfile_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_read_two (
        .rd_idx    (bus.ReadRegTwo),
        .arr_data  (regs_q[bus.ReadRegTwo]),
        .we_a      (bus.RegWriteA),
        .wr_idx_a  (bus.WriteRegA),
        .wr_data_a (bus.WriteDataA),
        .we_b      (bus.RegWriteB),
        .wr_idx_b  (bus.WriteRegB),
        .wr_data_b (bus.WriteDataB),
        .ready     (ready_q),
        .rd_data   (rd_two)
    );

    assign bus.ReadDataOne = rd_one;
    assign bus.ReadDataTwo = rd_two;
    assign bus.Ready       = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share the same stimulus:
// dut0 with BYPASS = 0 and dut1 with BYPASS = 1 (both ZERO_REG = 1,
// CLEAR_LANES = 4, 32 x 32-bit).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    logic [4:0]  rd1 = '0;
    logic [4:0]  rd2 = '0;
    logic [4:0]  wa  = '0;
    logic [31:0] wda = '0;
    logic        wea = 1'b0;
    logic [4:0]  wb  = '0;
    logic [31:0] wdb = '0;
    logic        web = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 Clock = ~Clock;

    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();

    assign bus0.ReadRegOne = rd1;
    assign bus0.ReadRegTwo = rd2;
    assign bus0.WriteRegA  = wa;
    assign bus0.WriteDataA = wda;
    assign bus0.RegWriteA  = wea;
    assign bus0.WriteRegB  = wb;
    assign bus0.WriteDataB = wdb;
    assign bus0.RegWriteB  = web;

    assign bus1.ReadRegOne = rd1;
    assign bus1.ReadRegTwo = rd2;
    assign bus1.WriteRegA  = wa;
    assign bus1.WriteDataA = wda;
    assign bus1.RegWriteA  = wea;
    assign bus1.WriteRegB  = wb;
    assign bus1.WriteDataB = wdb;
    assign bus1.RegWriteB  = web;

    regfile_mp #(
        .DATA_WIDTH (32), .ADDR_WIDTH (5), .CLEAR_LANES (4),
        .ZERO_REG (1), .BYPASS (0)
    ) dut0 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    regfile_mp #(
        .DATA_WIDTH (32), .ADDR_WIDTH (5), .CLEAR_LANES (4),
        .ZERO_REG (1), .BYPASS (1)
    ) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic no_writes();
        wea = 1'b0;
        web = 1'b0;
    endtask

    initial begin
        // Reset held for two edges with a write to reg 3 presented throughout
        // reset and the whole sweep.
        wa = 5'd3; wda = 32'h0000_0055; wea = 1'b1; rd1 = 5'd3;
        tick();
        tick();
        chk("reset_ready0", {31'b0, bus0.Ready}, 32'd0);
        chk("reset_ready1", {31'b0, bus1.Ready}, 32'd0);
        chk("reset_rd1_dut1", bus1.ReadDataOne, 32'd0);
        Reset = 1'b0;

        // Sweep: Ready stays low for 7 edges and rises on the 8th.
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 8) no_writes();
            #1;
            chk($sformatf("sweep_ready0_e%0d", i), {31'b0, bus0.Ready}, (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("sweep_ready1_e%0d", i), {31'b0, bus1.Ready}, (i == 8) ? 32'd1 : 32'd0);
            if (i < 8) chk($sformatf("sweep_rd1_forced0_e%0d", i), bus1.ReadDataOne, 32'd0);
        end

        // Every register reads 0 via both ports (reg 3 included).
        for (int r = 0; r < 32; r++) begin
            rd1 = 5'(r);
            rd2 = 5'(31 - r);
            #1;
            chk($sformatf("clr0_p1_r%0d", r), bus0.ReadDataOne, 32'd0);
            chk($sformatf("clr0_p2_r%0d", 31 - r), bus0.ReadDataTwo, 32'd0);
            chk($sformatf("clr1_p1_r%0d", r), bus1.ReadDataOne, 32'd0);
        end

        // Write A reg 5 = 4; no-bypass instance sees old value this cycle.
        wa = 5'd5; wda = 32'h0000_0004; wea = 1'b1; rd1 = 5'd5;
        #1;
        chk("wr5_same_cycle_nobyp", bus0.ReadDataOne, 32'd0);
        chk("wr5_same_cycle_byp", bus1.ReadDataOne, 32'h0000_0004);
        tick();
        no_writes();
        #1;
        chk("wr5_next_nobyp", bus0.ReadDataOne, 32'h0000_0004);
        chk("wr5_next_byp", bus1.ReadDataOne, 32'h0000_0004);

        // Both ports to reg 9: B wins in bypass and in storage.
        wa = 5'd9; wda = 32'h0000_0011; wea = 1'b1;
        wb = 5'd9; wdb = 32'h0000_0022; web = 1'b1;
        rd2 = 5'd9;
        #1;
        chk("prio9_bypass", bus1.ReadDataTwo, 32'h0000_0022);
        chk("prio9_nobyp_old", bus0.ReadDataTwo, 32'd0);
        tick();
        no_writes();
        #1;
        chk("prio9_stored_dut0", bus0.ReadDataTwo, 32'h0000_0022);
        chk("prio9_stored_dut1", bus1.ReadDataTwo, 32'h0000_0022);

        // Independent writes on both ports in one cycle.
        wa = 5'd10; wda = 32'hA5A5_0001; wea = 1'b1;
        wb = 5'd11; wdb = 32'h5A5A_0002; web = 1'b1;
        rd1 = 5'd10; rd2 = 5'd11;
        #1;
        chk("dual_byp_a", bus1.ReadDataOne, 32'hA5A5_0001);
        chk("dual_byp_b", bus1.ReadDataTwo, 32'h5A5A_0002);
        tick();
        no_writes();
        #1;
        chk("dual_stored_a", bus0.ReadDataOne, 32'hA5A5_0001);
        chk("dual_stored_b", bus0.ReadDataTwo, 32'h5A5A_0002);

        // Register 0: writes dropped, reads 0 even with bypass.
        wa = 5'd0; wda = 32'hFFFF_FFFF; wea = 1'b1;
        wb = 5'd0; wdb = 32'h1234_5678; web = 1'b1;
        rd1 = 5'd0; rd2 = 5'd0;
        #1;
        chk("zero_same_dut0", bus0.ReadDataOne, 32'd0);
        chk("zero_same_dut1", bus1.ReadDataOne, 32'd0);
        chk("zero_same_dut1_p2", bus1.ReadDataTwo, 32'd0);
        tick();
        no_writes();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("zero_after_dut0_c%0d", c), bus0.ReadDataOne, 32'd0);
            chk($sformatf("zero_after_dut1_c%0d", c), bus1.ReadDataOne, 32'd0);
            tick();
        end

        // Earlier write to reg 3 during the sweep left no trace.
        rd1 = 5'd3;
        #1;
        chk("sweep_write_ignored", bus0.ReadDataOne, 32'd0);

        // Load 0x1234 into regs 4 and 20, then reset mid-sweep.
        wa = 5'd4;  wda = 32'h0000_1234; wea = 1'b1;
        wb = 5'd20; wdb = 32'h0000_1234; web = 1'b1;
        tick();
        no_writes();
        rd1 = 5'd4; rd2 = 5'd20;
        #1;
        chk("pre_reset_r4", bus0.ReadDataOne, 32'h0000_1234);
        chk("pre_reset_r20", bus0.ReadDataTwo, 32'h0000_1234);

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("first_sweep_ready_e%0d", i), {31'b0, bus0.Ready}, 32'd0);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("resweep_ready0_e%0d", i), {31'b0, bus0.Ready}, (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("resweep_ready1_e%0d", i), {31'b0, bus1.Ready}, (i == 8) ? 32'd1 : 32'd0);
        end
        #1;
        chk("resweep_r4_dut0", bus0.ReadDataOne, 32'd0);
        chk("resweep_r20_dut0", bus0.ReadDataTwo, 32'd0);
        chk("resweep_r4_dut1", bus1.ReadDataOne, 32'd0);
        chk("resweep_r20_dut1", bus1.ReadDataTwo, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
